// File: rtl/packs.sv
// Shared types and constants for the display path.
package packs;

    typedef logic [3:0] BCDnumber_t;

    localparam int N_DIGITS = 4;

    // Cathodes {g,f,e,d,c,b,a}, active-low.
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_OFF  = 7'h7F;
    localparam seg7_t SEG_DASH = 7'b0111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 render as a dash.
module bcd_to_seg7
    import packs::*;
(
    input  BCDnumber_t bcd,
    output seg7_t      seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed seven-segment scanner with per-frame input snapshot and dead time.
// Optional leading-zero blanking is built when BCD_SCAN_LZB_EN is defined.
module bcd_scan_display
    import packs::*;
#(
    parameter int CLK_DIV     = 1000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  BCDnumber_t [N_DIGITS-1:0]    digit,
    input  logic       [N_DIGITS-1:0]    dp_in,
    output logic       [N_DIGITS-1:0]    an,
    output seg7_t                        seg,
    output logic                         dp,
    output logic                         frame
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);

    generate
        if (CLK_DIV < 2 || DEAD_CYCLES < 0 || DEAD_CYCLES >= CLK_DIV) begin : g_param_check
            $error("bcd_scan_display: need CLK_DIV >= 2 and 0 <= DEAD_CYCLES < CLK_DIV");
        end
    endgenerate

    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          idx;
    BCDnumber_t [N_DIGITS-1:0] shadow;
    logic [N_DIGITS-1:0]       shadow_dp;
    logic [N_DIGITS-1:0]       blank;
    seg7_t                     seg_dec;
    logic                      drive;

    // Gated by rst so the pulse stays low while reset is held.
    assign frame = rst & en & (cnt == '0) & (idx == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow    <= '0;
            shadow_dp <= '0;
        end else if (frame) begin
            shadow    <= digit;
            shadow_dp <= dp_in;
        end
    end

`ifdef BCD_SCAN_LZB_EN
    // A digit stays blank only while it and every higher digit are zero without a dot.
    always_comb begin
        logic zrun;
        zrun  = 1'b1;
        blank = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zrun     = zrun & (shadow[i] == 4'd0) & ~shadow_dp[i];
            blank[i] = zrun;
        end
    end
`else
    assign blank = '0;
`endif

    bcd_to_seg7 u_dec (
        .bcd (shadow[idx]),
        .seg (seg_dec)
    );

    assign drive = en & (cnt >= DEAD_END) & ~blank[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (drive) begin
            an  <= ~(N_DIGITS'(1) << idx);
            seg <= seg_dec;
            dp  <= ~shadow_dp[idx];
        end else begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized and directed bench for bcd_scan_display against a slot/tick reference model.
module tb_bcd_scan_display;

    localparam int CLK_DIV = 8;
    localparam int DEAD    = 2;
    localparam int FRAME   = 4 * CLK_DIV;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic            clk;
    logic            rst;
    logic            en;
    logic [3:0][3:0] digit;
    logic [3:0]      dp_in;
    logic [3:0]      an;
    logic [6:0]      seg;
    logic            dp;
    logic            frame;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: enabled cycles since (re)start, plus the snapshot it should hold.
    int         tick = 0;
    logic [3:0] msh [4];
    logic [3:0] mdp;

    bcd_scan_display #(.CLK_DIV(CLK_DIV), .DEAD_CYCLES(DEAD)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .digit (digit),
        .dp_in (dp_in),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .frame (frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        tick = 0;
        for (int k = 0; k < 4; k++) msh[k] = 4'd0;
        mdp = 4'd0;
    endtask

    // One clock: check frame before the edge, predict pins, check them just after the edge.
    task automatic step();
        int         c;
        int         ix;
        logic       fr_e;
        logic       zrun;
        logic [3:0] blank;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        @(negedge clk);
        c    = tick % CLK_DIV;
        ix   = (tick / CLK_DIV) % 4;
        fr_e = rst && en && (c == 0) && (ix == 0);
        check("frame", {31'd0, frame}, {31'd0, fr_e});
        blank = 4'd0;
`ifdef BCD_SCAN_LZB_EN
        zrun = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            zrun     = zrun && (msh[k] == 4'd0) && !mdp[k];
            blank[k] = zrun;
        end
`else
        zrun = 1'b0;
`endif
        an_e  = 4'hF;
        seg_e = 7'h7F;
        dp_e  = 1'b1;
        if (rst && en && c >= DEAD && !blank[ix]) begin
            an_e[ix] = 1'b0;
            seg_e    = SEG_TAB[msh[ix]];
            dp_e     = ~mdp[ix];
        end
        if (!rst) model_reset();
        else begin
            if (fr_e) begin
                for (int k = 0; k < 4; k++) msh[k] = digit[k];
                mdp = dp_in;
            end
            tick = en ? tick + 1 : 0;
        end
        @(posedge clk);
        #1;
        check("an",  {28'd0, an},  {28'd0, an_e});
        check("seg", {25'd0, seg}, {25'd0, seg_e});
        check("dp",  {31'd0, dp},  {31'd0, dp_e});
    endtask

    // Step at least once, until the model's frame position equals m.
    task automatic run_to(input int m);
        int guard;
        guard = 0;
        do begin
            step();
            guard++;
        end while ((tick % FRAME) != m && guard < 200);
        if (guard >= 200) check("run_to_bound", tick % FRAME, m);
    endtask

    initial begin
        model_reset();
        rst   = 1'b1;
        en    = 1'b0;
        digit = '0;
        dp_in = 4'd0;

        // Asynchronous reset before any clock edge.
        #3 rst = 1'b0;
        #1;
        check("rst_an",    {28'd0, an},  32'hF);
        check("rst_seg",   {25'd0, seg}, 32'h7F);
        check("rst_dp",    {31'd0, dp},  32'h1);
        check("rst_frame", {31'd0, frame}, 32'h0);
        step();
        step();

        // Basic scan: {1,2,3,4}, dot on digit 2.
        rst   = 1'b1;
        en    = 1'b1;
        digit = {4'd1, 4'd2, 4'd3, 4'd4};
        dp_in = 4'b0100;
        run_to(4);
        check("slot0_an",  {28'd0, an},  32'b1110);
        check("slot0_seg", {25'd0, seg}, 32'b0011001);
        run_to(20);
        check("slot2_an",  {28'd0, an},  32'b1011);
        check("slot2_seg", {25'd0, seg}, 32'b0100100);
        check("slot2_dp",  {31'd0, dp},  32'h0);

        // Tearing: change digit[0] during slot 1; it shows only after the next frame.
        run_to(8);
        digit[0] = 4'd7;
        run_to(4);
        check("tear_seg", {25'd0, seg}, 32'b1111000);

        // Invalid code on digit 3.
        digit[3] = 4'hC;
        run_to(0);
        run_to(28);
        check("dash_an",  {28'd0, an},  32'b0111);
        check("dash_seg", {25'd0, seg}, 32'b0111111);

        // Leading zeros {0,0,5,0}.
        digit = {4'd0, 4'd0, 4'd5, 4'd0};
        dp_in = 4'd0;
        run_to(0);
        run_to(6);
        check("lz_s0_an",  {28'd0, an},  32'b1110);
        check("lz_s0_seg", {25'd0, seg}, 32'b1000000);
        run_to(14);
        check("lz_s1_an",  {28'd0, an},  32'b1101);
        check("lz_s1_seg", {25'd0, seg}, 32'b0010010);
        run_to(30);
`ifdef BCD_SCAN_LZB_EN
        check("lz_s3_an", {28'd0, an}, 32'hF);
`else
        check("lz_s3_an",  {28'd0, an},  32'b0111);
        check("lz_s3_seg", {25'd0, seg}, 32'b1000000);
`endif

        // All zeros.
        digit = '0;
        run_to(0);
        run_to(6);
        check("z_s0_an", {28'd0, an}, 32'b1110);
        run_to(14);
`ifdef BCD_SCAN_LZB_EN
        check("z_s1_an", {28'd0, an}, 32'hF);
`else
        check("z_s1_an", {28'd0, an}, 32'b1101);
`endif

        // Enable dropped in slot 2, then restored.
        digit = {4'd9, 4'd8, 4'd6, 4'd3};
        run_to(20);
        en = 1'b0;
        step();
        check("en_off_an", {28'd0, an}, 32'hF);
        repeat (3) step();
        en = 1'b1;
        repeat (40) step();

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < 4; k++) digit[k] = 4'($urandom_range(0, 15));
                dp_in = 4'($urandom);
            end
            if ($urandom_range(0, 59) == 0) en = ~en;
            step();
        end

        // Reset asserted mid-DRIVE acts without a clock.
        en = 1'b1;
        digit = {4'd2, 4'd0, 4'd1, 4'd8};
        run_to(0);
        run_to(5);
        check("pre_rst_an", {28'd0, an}, 32'b1110);
        rst = 1'b0;
        #1;
        check("mid_rst_an",    {28'd0, an},  32'hF);
        check("mid_rst_seg",   {25'd0, seg}, 32'h7F);
        check("mid_rst_dp",    {31'd0, dp},  32'h1);
        check("mid_rst_frame", {31'd0, frame}, 32'h0);
        model_reset();
        step();
        step();
        rst = 1'b1;
        repeat (40) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
